// File: rtl/fpa_arb_pkg.sv
// Shared types and constants for the fpa_arbiter slice: FSM states, FP field
// layout and stats counter width.
package fpa_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

    localparam int SIGN_W  = 1;
    localparam int EXP_W   = 8;
    localparam int MANT_W  = 23;
    localparam int FP_W    = SIGN_W + EXP_W + MANT_W;

    localparam int STATS_W = 16;
    localparam logic [STATS_W-1:0] STATS_MAX = '1;

    // Result word layout is {sign, exp, mant}, MSB first.
    function automatic logic [FP_W-1:0] fp_pack(
        input logic              sgn,
        input logic [EXP_W-1:0]  expo,
        input logic [MANT_W-1:0] mant
    );
        return {sgn, expo, mant};
    endfunction

endpackage

// File: rtl/fpa_rr_pick.sv
// Combinational round-robin picker: first asserted req at or after rr (mod
// NREQ) wins; returns one-hot grant, its index and an any-grant flag.
module fpa_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int          j;
    logic [IW-1:0] jj;

    // Scan from the farthest position down so the closest-to-rr requester
    // is the last one written and therefore wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        jj  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j  = (int'(rr) + k) % NREQ;
            jj = IW'(j);
            if (req[jj]) begin
                gnt     = '0;
                gnt[jj] = 1'b1;
                idx     = jj;
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpa_arbiter.sv
// Round-robin scheduler sharing one pipelined FP adder between NREQ clients;
// tags each issue through the adder latency and routes results back.
// Optional per-requester grant counters when FPA_ARB_STATS_EN is defined.
module fpa_arbiter
    import fpa_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*32-1:0]  req_a,
    input  logic [NREQ*32-1:0]  req_b,
    input  logic [NREQ-1:0]     req_sub,
    input  logic                flush,
    output logic [31:0]         fpa_a,
    output logic [31:0]         fpa_b,
    output logic                fpa_decidebit,
    input  logic                fpa_sign,
    input  logic [7:0]          fpa_exp,
    input  logic [22:0]         fpa_mant,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [31:0]         rsp_data,
    output logic                busy,
    output logic [1:0]          dbg_state
`ifdef FPA_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]  grant_cnt
`endif
);

    localparam int IW = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    // Handshake: a request transfers on a rising edge where req_valid[i] and
    // req_ready[i] are both high; req_ready never depends on a transfer.
    arb_state_t    state_q, state_d;
    logic [IW-1:0] rr_q;
    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            grant_en;
    logic            xfer;
    logic [LAT-1:0]  tag_vld;
    logic [IW-1:0]   tag_idx [LAT];

    fpa_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req  (req_valid),
        .rr   (rr_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign grant_en  = (state_q != ST_DRAIN) && !flush;
    assign req_ready = grant_en ? pick_gnt : '0;
    assign xfer      = grant_en && pick_any;
    assign busy      = |tag_vld;
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (flush)
                    state_d = ST_DRAIN;
                else if (|req_valid)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (flush)
                    state_d = ST_DRAIN;
                else if (!xfer && !busy)
                    state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (!busy && !flush)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            if (xfer)
                rr_q <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    // Operand registers hold their last value when nothing is issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpa_a         <= '0;
            fpa_b         <= '0;
            fpa_decidebit <= 1'b0;
        end else if (xfer) begin
            fpa_a         <= req_a[32*pick_idx +: 32];
            fpa_b         <= req_b[32*pick_idx +: 32];
            fpa_decidebit <= req_sub[pick_idx];
        end
    end

    // Tag pipe mirrors the adder latency; the tail tag owns the result
    // presented on the adder outputs at that edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_vld <= '0;
            for (int k = 0; k < LAT; k++)
                tag_idx[k] <= '0;
        end else begin
            tag_vld[0] <= xfer;
            tag_idx[0] <= pick_idx;
            for (int k = 1; k < LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_idx[k] <= tag_idx[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else if (tag_vld[LAT-1]) begin
            rsp_valid <= ONE_HOT0 << tag_idx[LAT-1];
            rsp_data  <= fp_pack(fpa_sign, fpa_exp, fpa_mant);
        end else begin
            rsp_valid <= '0;
        end
    end

`ifdef FPA_ARB_STATS_EN
    logic [NREQ*STATS_W-1:0] grant_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt_q <= '0;
        end else if (xfer) begin
            for (int i = 0; i < NREQ; i++) begin
                if (pick_gnt[i] && grant_cnt_q[i*STATS_W +: STATS_W] != STATS_MAX)
                    grant_cnt_q[i*STATS_W +: STATS_W] <= grant_cnt_q[i*STATS_W +: STATS_W] + 1'b1;
            end
        end
    end

    assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_fpa_arbiter.sv
// Directed bench for fpa_arbiter: stand-in adder pipeline, scoreboard of
// expected responses keyed by arrival cycle, immediate-assertion checks.
module tb_fpa_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 3;
    localparam int W    = 16 + NREQ + 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ-1:0]   req_sub;
    logic              flush;
    logic [31:0]       fpa_a;
    logic [31:0]       fpa_b;
    logic              fpa_decidebit;
    logic              fpa_sign;
    logic [7:0]        fpa_exp;
    logic [22:0]       fpa_mant;
    logic [NREQ-1:0]   rsp_valid;
    logic [31:0]       rsp_data;
    logic              busy;
    logic [1:0]        dbg_state;
`ifdef FPA_ARB_STATS_EN
    logic [NREQ*16-1:0] grant_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rsp_cnt = 0;
    logic [W-1:0] exp_q[$];

    fpa_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_sub       (req_sub),
        .flush         (flush),
        .fpa_a         (fpa_a),
        .fpa_b         (fpa_b),
        .fpa_decidebit (fpa_decidebit),
        .fpa_sign      (fpa_sign),
        .fpa_exp       (fpa_exp),
        .fpa_mant      (fpa_mant),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .busy          (busy),
        .dbg_state     (dbg_state)
`ifdef FPA_ARB_STATS_EN
        ,
        .grant_cnt     (grant_cnt)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in adder: asymmetric in a/b and sensitive to the op select, so
    // routing errors show up; the arbiter never looks inside the value.
    function automatic logic [31:0] model_fpa(input logic [31:0] a, input logic [31:0] b,
                                              input logic s);
        return s ? (a - b) : (a + {b[30:0], b[31]});
    endfunction

    logic [31:0] mp0, mp1;
    always @(posedge clk) begin
        mp0 <= model_fpa(fpa_a, fpa_b, fpa_decidebit);
        mp1 <= mp0;
    end
    assign {fpa_sign, fpa_exp, fpa_mant} = mp1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // scoreboard monitor
    logic [NREQ-1:0] mon_xf;
    logic [W-1:0]    mon_e;
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
        end else begin
            mon_xf = req_valid & req_ready;
            for (int i = 0; i < NREQ; i++) begin
                if (mon_xf[i])
                    exp_q.push_back({16'(cyc + LAT + 1), NREQ'(1) << i,
                                     model_fpa(req_a[32*i +: 32], req_b[32*i +: 32], req_sub[i])});
            end
            if (rsp_valid != '0) begin
                rsp_cnt++;
                chk("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_valid", 64'(rsp_valid), 64'(mon_e[35:32]));
                    chk("rsp_data", 64'(rsp_data), 64'(mon_e[31:0]));
                    chk("rsp_cycle", 64'(cyc[15:0]), 64'(mon_e[51:36]));
                end
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input int i, input logic [31:0] a, input logic [31:0] b,
                            input logic s);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_sub[i]        = s;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++)
            drive_op(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int n;
    int w;
    int base;
    logic [NREQ*16-1:0] exp_cnt;

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        flush     = 1'b0;

        // reset values
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_fpa_a", 64'(fpa_a), 64'd0);
        chk("rst_fpa_b", 64'(fpa_b), 64'd0);
        chk("rst_decidebit", 64'(fpa_decidebit), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'd0);
        tick();
        reset = 1'b1;
        tick();

        // full contention from rr=0
        rand_ops();
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("contend_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
            tick();
            rand_ops();
        end
        req_valid = '0;
        repeat (LAT + 3) tick();
        chk("contend_drained", 64'(exp_q.size()), 64'd0);

        // single request from requester 1
        drive_op(1, 32'h6BF3A0C3, 32'h6B8E5F1C, 1'b0);
        req_valid = 4'b0010;
        @(negedge clk);
        chk("single_ready", 64'(req_ready), 64'b0010);
        tick();
        req_valid = '0;
        chk("single_fpa_a", 64'(fpa_a), 64'h6BF3A0C3);
        chk("single_fpa_b", 64'(fpa_b), 64'h6B8E5F1C);
        chk("single_decidebit", 64'(fpa_decidebit), 64'd0);
        n = 1;
        while (rsp_valid == '0 && n < 12) begin
            tick();
            n++;
        end
        chk("single_latency", 64'(n), 64'(LAT + 1));
        chk("single_rsp_valid", 64'(rsp_valid), 64'b0010);
        chk("single_rsp_data", 64'(rsp_data), 64'(model_fpa(32'h6BF3A0C3, 32'h6B8E5F1C, 1'b0)));
        tick();
        chk("single_rsp_pulse", 64'(rsp_valid), 64'd0);
        repeat (2) tick();

        // fairness: requester 3 always valid, requester 0 every other cycle
        rand_ops();
        req_valid = 4'b1000;
        for (int t = 0; t < 6; t++) begin
            req_valid[0] = 1'b1;
            w = 0;
            @(negedge clk);
            while (!req_ready[0] && w < 8) begin
                tick();
                w++;
                @(negedge clk);
            end
            chk("fair_wait_le1", 64'(w <= 1), 64'd1);
            tick();
            req_valid[0] = 1'b0;
            rand_ops();
            tick();
        end
        req_valid = '0;
        repeat (LAT + 3) tick();
        chk("fair_drained", 64'(exp_q.size()), 64'd0);

        // flush with three operations in flight
        base = rsp_cnt;
        for (int i = 0; i < 3; i++) begin
            drive_op(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
            req_valid = NREQ'(1) << i;
            @(negedge clk);
            chk("flush_pre_grant", 64'(req_ready), 64'(req_valid));
            tick();
        end
        req_valid = 4'b1000;
        flush     = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("flush_ready0", 64'(req_ready), 64'd0);
            tick();
        end
        chk("flush_rsp_count", 64'(rsp_cnt - base), 64'd3);
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_state_drain", 64'(dbg_state), 64'd2);
        flush = 1'b0;
        @(negedge clk);
        chk("flush_drop_ready", 64'(req_ready), 64'd0);
        tick();
        @(negedge clk);
        chk("flush_state_idle", 64'(dbg_state), 64'd0);
        chk("flush_resume", 64'(req_ready), 64'b1000);
        tick();
        req_valid = '0;
        repeat (LAT + 3) tick();
        chk("flush_drained", 64'(exp_q.size()), 64'd0);

        // reset with two operations in flight and one response showing
        for (int i = 0; i < 3; i++) begin
            drive_op(i, $urandom, $urandom, 1'b1);
            req_valid = NREQ'(1) << i;
            tick();
        end
        req_valid = '0;
        tick();
        chk("rstmid_rsp_before", 64'(rsp_valid), 64'b0001);
        reset = 1'b0;
        #1;
        chk("rstmid_rsp_valid0", 64'(rsp_valid), 64'd0);
        chk("rstmid_busy0", 64'(busy), 64'd0);
        chk("rstmid_fpa_a0", 64'(fpa_a), 64'd0);
        repeat (2) tick();
        reset = 1'b1;
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            chk("rstmid_no_stale", 64'(rsp_valid), 64'd0);
            tick();
        end

`ifdef FPA_ARB_STATS_EN
        // stats: ten transfers from requester 2
        req_valid = 4'b0100;
        repeat (10) tick();
        req_valid = '0;
        exp_cnt = '0;
        exp_cnt[2*16 +: 16] = 16'd10;
        chk("stats_ten", 64'(grant_cnt), 64'(exp_cnt));
        exp_cnt[2*16 +: 16] = 16'hFFFF;
        force dut.grant_cnt_q = exp_cnt;
        #1;
        release dut.grant_cnt_q;
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        chk("stats_saturate", 64'(grant_cnt), 64'(exp_cnt));
        repeat (LAT + 3) tick();
`endif

        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpa_arbiter.md
# fpa_arbiter

Round-robin scheduler that shares one pipelined floating-point adder (`fpa`) between NREQ requesters. Each requester offers an operand pair with a valid/ready handshake. The arbiter grants at most one per cycle and drives the adder's operand inputs. It tracks each issued operation through the adder's fixed latency and returns the IEEE-754 single result to the owning requester. It sits between the compute clients and the single `fpa` instance.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `LAT`, 3: `fpa` latency in clock edges from operand capture to valid result (1..8).
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NREQ: requester i has an operation pending.
- `req_ready`  out  NREQ: one-hot grant; a transfer happens when `req_valid[i] & req_ready[i]`.
- `req_a`, `req_b`  in  NREQ*32: operands; slice i is `[32*i+31:32*i]`.
- `req_sub`  in  NREQ: per-requester `decidebit` (0 = add, 1 = subtract).
- `flush`  in  1: stop granting and drain the pipeline.
- `fpa_a`, `fpa_b`  out  32: adder operands.
- `fpa_decidebit`  out  1: adder operation select.
- `fpa_sign`  in  1, `fpa_exp`  in  8, `fpa_mant`  in  23: adder result.
- `rsp_valid`  out  NREQ: one-hot, single-cycle result strobe.
- `rsp_data`  out  32: `{sign, exp, mant}`.
- `busy`  out  1: high when any operation is in flight.

## Operation
- The state machine has three states: IDLE, RUN, DRAIN.
  - IDLE → RUN: any `req_valid` high and `flush` low.
  - RUN → IDLE: no grant this cycle and the tag pipe is empty.
  - RUN → DRAIN: `flush` high.
  - IDLE → DRAIN: `flush` high.
  - DRAIN → IDLE: tag pipe empty and `flush` low. While in DRAIN, `flush` may stay high indefinitely.
- Grants are only issued in IDLE or RUN with `flush` low. In DRAIN, `req_ready` = 0.
- Round-robin rule:
  - Pointer `rr` (reset 0).
  - Grant goes to the first i with `req_valid[i]`, searching `rr, rr+1, …` mod NREQ.
  - After a grant to i, `rr` becomes (i+1) mod NREQ. With no grant, `rr` is unchanged.
- `req_ready` is combinational from `req_valid`, `rr`, state and `flush`. It is at most one-hot.
- On a transfer, the requester's `req_a`, `req_b` and `req_sub` are registered onto `fpa_a`, `fpa_b` and `fpa_decidebit`.
- With no transfer, the `fpa_*` outputs hold their previous values.
- Tag pipe: a LAT-deep shift register of `{vld, idx[$clog2(NREQ)-1:0]}`. On each edge it shifts in `{transfer, granted index}`.
- When the tag emerging from the pipe has `vld` set:
  - `rsp_valid[idx]` is set for one cycle.
  - `rsp_data` is loaded from the `fpa_*` result inputs.
- Otherwise `rsp_valid` = 0 and `rsp_data` holds its value.
- Responses have no backpressure. Requesters must accept a response in the cycle it is strobed.
- `busy` = OR of all tag `vld` bits.

## Timing
- Reset values: `req_ready` = 0 (combinational; state is IDLE with no valid), `fpa_a`/`fpa_b` = 0, `fpa_decidebit` = 0, `rsp_valid` = 0, `rsp_data` = 0, `busy` = 0, `rr` = 0, all tags cleared.
- Reset asserted mid-operation discards every in-flight operation. No stale response appears after release.
- Latency:
  - Transfer on edge E0: `fpa_*` operands valid after E0.
  - Result sampled on edge E0+LAT; `rsp_valid` is high for the cycle following that edge.
  - End-to-end latency is LAT+1 edges.
- Throughput is one operation per cycle, sustained across any mix of requesters.
- When `flush` rises in the same cycle as a `req_valid`, `flush` wins and no grant is made.
- A response and a new grant to the same requester in the same cycle are independent and both occur.

## Configuration
- `FPA_ARB_STATS_EN` defined: adds output `grant_cnt` (NREQ*16).
  - Slice i counts transfers from requester i and saturates at 16'hFFFF.
  - Cleared by `reset`.
- Without the macro, the port and counters are absent. All other behaviour is identical.

## Structure
- Package `fpa_arb_pkg` holds:
  - the state enum (IDLE, RUN, DRAIN);
  - FP field widths (1/8/23) and the `{sign, exp, mant}` packing constant;
  - the stats counter width (16).
- One sub-module, `fpa_rr_pick`: a combinational round-robin picker. Inputs are `req` and `rr`; outputs are a one-hot grant and its index.

## Test plan
- **Single request.** Requester 1 valid with a=32'h6BF3A0C3, b=32'h6B8E5F1C, sub=0.
  - `req_ready` = 4'b0010 in that cycle.
  - `fpa_a` = 32'h6BF3A0C3 after the edge.
  - `rsp_valid` = 4'b0010 for exactly one cycle, LAT+1 edges after the transfer.
  - `rsp_data` equals the model adder output.
- **Full contention.** All four requesters held valid from IDLE with rr=0.
  - Grants 0,1,2,3,0,… on consecutive cycles.
  - Responses follow in the same order, one per cycle.
- **Fairness under skew.** Requester 3 always valid, requester 0 valid in alternate cycles.
  - Requester 0 is never starved; it is granted within 2 cycles of asserting valid.
- **Flush.** Assert flush with 3 operations in flight.
  - `req_ready` = 0 throughout.
  - Exactly 3 responses arrive; `busy` falls; state reaches IDLE after flush drops.
  - Grants resume on the next valid.
- **Reset mid-flight.** Drive `reset` low with 2 operations in flight.
  - `rsp_valid` = 0 immediately.
  - After release, no response appears for LAT+2 cycles without new requests.
- **Stats (`FPA_ARB_STATS_EN`).**
  - 10 transfers from requester 2 give `grant_cnt[2]` = 10 and all other slices 0.
  - A forced 16'hFFFF value stays at 16'hFFFF on the next grant.
